bp_sacc_vdp_lanes: RTL and testbench



---
 rtl/bp_sacc_vdp_lanes.sv | 204 ++++++++++++++++++++
 tb/tb_bp_sacc_vdp_lanes.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_sacc_vdp_lanes.sv
// Multi-lane streaming vector dot-product engine: a CSR slave programs operands/length,
// a single-outstanding memory master fetches one beat of A then B and accumulates per beat.
module bp_sacc_vdp_lanes #(
  parameter int lanes_p          = 4,
  parameter int elem_width_p     = 32,
  parameter int acc_width_p      = 64,
  parameter int len_width_p      = 16,
  parameter int paddr_width_p    = 40,
  parameter int csr_addr_width_p = 8,
  parameter int data_width_p     = 64
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [csr_addr_width_p-1:0]       csr_cmd_addr_i,
  input  logic [data_width_p-1:0]           csr_cmd_data_i,
  input  logic                              csr_cmd_w_i,
  input  logic                              csr_cmd_v_i,
  output logic                              csr_cmd_ready_o,
  output logic [data_width_p-1:0]           csr_resp_data_o,
  output logic                              csr_resp_v_o,
  input  logic                              csr_resp_yumi_i,
  output logic [paddr_width_p-1:0]          mem_cmd_addr_o,
  output logic                              mem_cmd_v_o,
  input  logic                              mem_cmd_yumi_i,
  input  logic [lanes_p*elem_width_p-1:0]   mem_resp_data_i,
  input  logic                              mem_resp_v_i,
  output logic                              mem_resp_ready_o
);

  localparam int beat_bytes_lp = lanes_p * elem_width_p / 8;
  localparam logic [paddr_width_p-1:0] beat_inc_lp    = paddr_width_p'(beat_bytes_lp);
  localparam logic [paddr_width_p-1:0] align_mask_lp  = ~(beat_inc_lp - paddr_width_p'(1));
  localparam logic [len_width_p-1:0]   lanes_len_lp   = len_width_p'(lanes_p);
  localparam logic [csr_addr_width_p-1:0] addr_a_lp      = csr_addr_width_p'(8'h00);
  localparam logic [csr_addr_width_p-1:0] addr_b_lp      = csr_addr_width_p'(8'h08);
  localparam logic [csr_addr_width_p-1:0] addr_len_lp    = csr_addr_width_p'(8'h10);
  localparam logic [csr_addr_width_p-1:0] addr_start_lp  = csr_addr_width_p'(8'h18);
  localparam logic [csr_addr_width_p-1:0] addr_status_lp = csr_addr_width_p'(8'h20);
  localparam logic [csr_addr_width_p-1:0] addr_result_lp = csr_addr_width_p'(8'h28);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_A, S_RESP_A, S_REQ_B, S_RESP_B, S_ACC, S_DONE
  } state_e;

  state_e                            r_state, w_state_next;
  logic [paddr_width_p-1:0]          r_a_base, r_b_base, r_a_ptr, r_b_ptr;
  logic [len_width_p-1:0]            r_len, r_rem, w_rem_next;
  logic [lanes_p*elem_width_p-1:0]   r_op_a, r_op_b;
  logic [acc_width_p-1:0]            r_acc, r_result, w_beat_sum;
  logic signed [2*elem_width_p-1:0]  w_prod;
  logic                              r_busy, r_done, r_resp_v;
  logic [data_width_p-1:0]           r_resp_data, w_rd_data;
  logic                              w_cmd_acc, w_wr, w_start;
  logic                              w_unused;

  assign w_cmd_acc = csr_cmd_v_i & ~r_resp_v;
  assign w_wr      = w_cmd_acc & csr_cmd_w_i;
  assign w_start   = w_wr & (csr_cmd_addr_i == addr_start_lp) & ~r_busy;
  assign w_unused  = ^csr_cmd_data_i;

  assign csr_cmd_ready_o = ~r_resp_v;
  assign csr_resp_v_o    = r_resp_v;
  assign csr_resp_data_o = r_resp_data;
  assign w_rem_next      = (r_rem > lanes_len_lp) ? (r_rem - lanes_len_lp) : '0;

  // CSR read mux, evaluated against the state seen at acceptance
  always_comb begin
    w_rd_data = '0;
    case (csr_cmd_addr_i)
      addr_a_lp:      w_rd_data = data_width_p'(r_a_base);
      addr_b_lp:      w_rd_data = data_width_p'(r_b_base);
      addr_len_lp:    w_rd_data = data_width_p'(r_len);
      addr_status_lp: w_rd_data = data_width_p'({r_done, r_busy});
      addr_result_lp: w_rd_data = data_width_p'(r_result);
      default:        w_rd_data = '0;
    endcase
  end

  // Per-beat signed partial sum; lanes past the remaining count are masked out
  always_comb begin
    w_beat_sum = '0;
    w_prod     = '0;
    for (int l = 0; l < lanes_p; l++) begin
      w_prod = (2*elem_width_p)'($signed(r_op_a[l*elem_width_p +: elem_width_p]))
             * (2*elem_width_p)'($signed(r_op_b[l*elem_width_p +: elem_width_p]));
      if (l < int'(r_rem)) begin
        w_beat_sum = w_beat_sum + acc_width_p'(w_prod);
      end else begin
        w_beat_sum = w_beat_sum;
      end
    end
  end

  // Next-state and memory handshake outputs
  always_comb begin
    w_state_next     = r_state;
    mem_cmd_v_o      = 1'b0;
    mem_cmd_addr_o   = r_a_ptr;
    mem_resp_ready_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_resp_ready_o = 1'b1;
        if (w_start) begin
          w_state_next = (r_len == '0) ? S_DONE : S_REQ_A;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_REQ_A: begin
        mem_cmd_v_o  = 1'b1;
        w_state_next = mem_cmd_yumi_i ? S_RESP_A : S_REQ_A;
      end
      S_RESP_A: begin
        mem_resp_ready_o = 1'b1;
        w_state_next     = mem_resp_v_i ? S_REQ_B : S_RESP_A;
      end
      S_REQ_B: begin
        mem_cmd_v_o    = 1'b1;
        mem_cmd_addr_o = r_b_ptr;
        w_state_next   = mem_cmd_yumi_i ? S_RESP_B : S_REQ_B;
      end
      S_RESP_B: begin
        mem_resp_ready_o = 1'b1;
        w_state_next     = mem_resp_v_i ? S_ACC : S_RESP_B;
      end
      S_ACC:   w_state_next = (w_rem_next == '0) ? S_DONE : S_REQ_A;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // CSR storage and the single pending response slot
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_a_base    <= '0;
      r_b_base    <= '0;
      r_len       <= '0;
      r_resp_v    <= 1'b0;
      r_resp_data <= '0;
    end else begin
      if (w_wr && !r_busy) begin
        case (csr_cmd_addr_i)
          addr_a_lp:   r_a_base <= csr_cmd_data_i[paddr_width_p-1:0];
          addr_b_lp:   r_b_base <= csr_cmd_data_i[paddr_width_p-1:0];
          addr_len_lp: r_len    <= csr_cmd_data_i[len_width_p-1:0];
          default:     ;
        endcase
      end
      if (w_cmd_acc) begin
        r_resp_v    <= 1'b1;
        r_resp_data <= csr_cmd_w_i ? '0 : w_rd_data;
      end else if (csr_resp_yumi_i) begin
        r_resp_v <= 1'b0;
      end
    end
  end

  // Operation datapath: working pointers, operand beats, accumulator and status
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_a_ptr  <= '0;
      r_b_ptr  <= '0;
      r_rem    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_acc   <= '0;
          r_done  <= 1'b0;
          r_busy  <= 1'b1;
          r_a_ptr <= r_a_base & align_mask_lp;
          r_b_ptr <= r_b_base & align_mask_lp;
          r_rem   <= r_len;
        end
        S_RESP_A: if (mem_resp_v_i) r_op_a <= mem_resp_data_i;
        S_RESP_B: if (mem_resp_v_i) r_op_b <= mem_resp_data_i;
        S_ACC: begin
          r_acc   <= r_acc + w_beat_sum;
          r_a_ptr <= r_a_ptr + beat_inc_lp;
          r_b_ptr <= r_b_ptr + beat_inc_lp;
          r_rem   <= w_rem_next;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_vdp_lanes.sv
// Directed bench for bp_sacc_vdp_lanes: sparse memory model, dot-product reference model,
// negedge memory responder/address checker and CSR tasks sampling #1 after the clock edge.
module tb_bp_sacc_vdp_lanes;

  localparam logic [7:0] A_OFF = 8'h00, B_OFF = 8'h08, LEN_OFF = 8'h10;
  localparam logic [7:0] START_OFF = 8'h18, STAT_OFF = 8'h20, RES_OFF = 8'h28;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [7:0]    csr_cmd_addr_i;
  logic [63:0]   csr_cmd_data_i;
  logic          csr_cmd_w_i, csr_cmd_v_i, csr_cmd_ready_o;
  logic [63:0]   csr_resp_data_o;
  logic          csr_resp_v_o, csr_resp_yumi_i;
  logic [39:0]   mem_cmd_addr_o;
  logic          mem_cmd_v_o, mem_cmd_yumi_i;
  logic [127:0]  mem_resp_data_i;
  logic          mem_resp_v_i, mem_resp_ready_o;

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int hold_idx = -1;
  logic [39:0] exp_addr[$];
  logic [39:0] pend_addr[$];
  int          pend_idx[$];
  logic [31:0] mem [longint];

  bp_sacc_vdp_lanes dut (
    .clk_i(clk), .reset_i(reset_i),
    .csr_cmd_addr_i(csr_cmd_addr_i), .csr_cmd_data_i(csr_cmd_data_i),
    .csr_cmd_w_i(csr_cmd_w_i), .csr_cmd_v_i(csr_cmd_v_i), .csr_cmd_ready_o(csr_cmd_ready_o),
    .csr_resp_data_o(csr_resp_data_o), .csr_resp_v_o(csr_resp_v_o), .csr_resp_yumi_i(csr_resp_yumi_i),
    .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void put(logic [39:0] p, logic [31:0] v);
    mem[longint'(p)] = v;
  endfunction

  // unwritten words read as recognisable garbage so masked lanes are exercised
  function automatic logic [31:0] mem_rd(logic [39:0] p);
    if (mem.exists(longint'(p))) return mem[longint'(p)];
    else return {16'hBAD0, p[15:0]};
  endfunction

  function automatic logic [127:0] beat_data(logic [39:0] p);
    logic [127:0] d;
    logic [39:0]  q;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      q = p + 40'(4 * l);
      d[l*32 +: 32] = mem_rd(q);
    end
    return d;
  endfunction

  // reference: plain signed dot product over the first len elements
  function automatic logic [63:0] model_dot(logic [39:0] a, logic [39:0] b, int len);
    longint acc, sa, sb;
    logic [39:0] pa, pb;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      pa = (a & ~40'hF) + 40'(4 * i);
      pb = (b & ~40'hF) + 40'(4 * i);
      sa = $signed(mem_rd(pa));
      sb = $signed(mem_rd(pb));
      acc = acc + sa * sb;
    end
    return acc;
  endfunction

  // memory slave plus request-address scoreboard, acting on the falling edge
  initial begin : mem_side
    mem_cmd_yumi_i  = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_data_i = '0;
    forever begin
      @(negedge clk);
      mem_cmd_yumi_i = mem_cmd_v_o && ($urandom_range(0, 3) != 0);
      if (mem_cmd_v_o && mem_cmd_yumi_i && !reset_i) begin
        if (exp_addr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_cmd: got addr 0x%0h, expected no request", mem_cmd_addr_o);
        end else begin
          check("mem_cmd_addr", {24'd0, mem_cmd_addr_o}, {24'd0, exp_addr.pop_front()});
        end
        pend_addr.push_back(mem_cmd_addr_o);
        pend_idx.push_back(beat_cnt);
        beat_cnt++;
      end
      if (pend_addr.size() != 0 && pend_idx[0] != hold_idx) begin
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = beat_data(pend_addr[0]);
        if (mem_resp_ready_o) begin
          void'(pend_addr.pop_front());
          void'(pend_idx.pop_front());
        end
      end else begin
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
      end
    end
  end

  task automatic csr_op(input bit w, input logic [7:0] adr, input logic [63:0] wd,
                        input int yd, output logic [63:0] rd);
    int n;
    @(posedge clk); #1;
    csr_cmd_v_i = 1'b1; csr_cmd_w_i = w; csr_cmd_addr_i = adr; csr_cmd_data_i = wd;
    n = 0;
    while (!csr_cmd_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    check("csr_cmd_ready_wait", n, (n < 50) ? n : 0);
    @(posedge clk); #1;
    csr_cmd_v_i = 1'b0; csr_cmd_w_i = 1'b0; csr_cmd_addr_i = '0; csr_cmd_data_i = '0;
    for (int k = 0; k < yd; k++) begin
      check("pending_cmd_ready", csr_cmd_ready_o, 0);
      @(posedge clk); #1;
    end
    check("csr_resp_v", csr_resp_v_o, 1);
    rd = csr_resp_data_o;
    csr_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    csr_resp_yumi_i = 1'b0;
  endtask

  task automatic csr_wr(input logic [7:0] adr, input logic [63:0] wd, input int yd);
    logic [63:0] rd;
    csr_op(1'b1, adr, wd, yd, rd);
    check("write_resp_zero", rd, 64'd0);
  endtask

  task automatic csr_rd(input logic [7:0] adr, output logic [63:0] rd);
    csr_op(1'b0, adr, 64'd0, 0, rd);
  endtask

  task automatic push_addrs(input logic [39:0] a, input logic [39:0] b, input int len);
    for (int k = 0; k < (len + 3) / 4; k++) begin
      exp_addr.push_back((a & ~40'hF) + 40'(16 * k));
      exp_addr.push_back((b & ~40'hF) + 40'(16 * k));
    end
  endtask

  task automatic wait_done();
    logic [63:0] st;
    int n;
    n = 0;
    st = '0;
    while (st[1] !== 1'b1 && n < 100) begin csr_rd(STAT_OFF, st); n++; end
    check("status_done", st, 64'h2);
  endtask

  task automatic run_op(input string tag, input logic [39:0] a, input logic [39:0] b,
                        input int len, output logic [63:0] res);
    csr_wr(A_OFF, {24'd0, a}, 0);
    csr_wr(B_OFF, {24'd0, b}, 0);
    csr_wr(LEN_OFF, 64'(len), 0);
    push_addrs(a, b, len);
    csr_wr(START_OFF, 64'd1, 0);
    wait_done();
    csr_rd(RES_OFF, res);
    check({tag, "_vs_model"}, res, model_dot(a, b, len));
    check({tag, "_addrs_done"}, exp_addr.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] r, s;
    int n;
    reset_i = 1'b1;
    csr_cmd_addr_i = '0; csr_cmd_data_i = '0; csr_cmd_w_i = 1'b0;
    csr_cmd_v_i = 1'b0; csr_resp_yumi_i = 1'b0;

    put(40'h100, 32'd1); put(40'h104, 32'd2); put(40'h108, 32'd3); put(40'h10C, 32'd4);
    put(40'h200, 32'd5); put(40'h204, 32'd6); put(40'h208, 32'd7); put(40'h20C, 32'd8);
    for (int i = 0; i < 6; i++) begin
      put(40'h1000 + 40'(4 * i), 32'(i + 1));
      put(40'hFF_FFFF_FFF0 + 40'(4 * i), 32'd1);
    end
    put(40'h300, 32'hFFFF_FFFF); put(40'h304, 32'hFFFF_FFFE); put(40'h308, 32'h7FFF_FFFF); put(40'h30C, 32'd0);
    put(40'h400, 32'd3); put(40'h404, 32'd4); put(40'h408, 32'd2); put(40'h40C, 32'd9);
    for (int i = 0; i < 24; i++) begin
      put(40'h500 + 40'(4 * i), 32'(i * 7 - 30));
      put(40'h600 + 40'(4 * i), 32'((i % 5) - 2));
    end

    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    check("rst_cmd_ready", csr_cmd_ready_o, 1);
    check("rst_resp_v", csr_resp_v_o, 0);
    check("rst_mem_cmd_v", mem_cmd_v_o, 0);
    csr_rd(STAT_OFF, r);
    check("rst_status", r, 64'h0);

    // 1: single beat, len field keeps only its low 16 bits
    csr_wr(LEN_OFF, 64'h1_0004, 0);
    csr_rd(LEN_OFF, r);
    check("len_truncated", r, 64'h4);
    run_op("t1", 40'h100, 40'h200, 4, r);
    check("t1_result", r, 64'd70);
    csr_rd(8'h30, r);
    check("unmapped_reads_zero", r, 64'd0);

    // 2: partial second beat with garbage in masked lanes, misaligned A base, B wrapping past 2^40
    run_op("t2", 40'h1004, 40'hFF_FFFF_FFF0, 6, r);
    check("t2_result", r, 64'd21);

    // 3: signed products
    run_op("t3", 40'h300, 40'h400, 4, r);
    check("t3_result", r, 64'h0000_0000_FFFF_FFF3);

    // 4: zero length finishes with no memory traffic
    csr_wr(LEN_OFF, 64'd0, 0);
    csr_wr(START_OFF, 64'd1, 0);
    csr_rd(STAT_OFF, r);
    check("t4_done_fast", r, 64'h2);
    csr_rd(RES_OFF, r);
    check("t4_result", r, 64'd0);

    // 5: writes and a second start while busy are answered but ignored
    csr_wr(A_OFF, 64'h500, 0);
    csr_wr(B_OFF, 64'h600, 0);
    csr_wr(LEN_OFF, 64'd24, 0);
    push_addrs(40'h500, 40'h600, 24);
    csr_wr(START_OFF, 64'd1, 0);
    csr_rd(STAT_OFF, r);
    check("t5_busy", r, 64'h1);
    csr_wr(A_OFF, 64'h7000, 5);
    csr_wr(START_OFF, 64'd1, 0);
    wait_done();
    csr_rd(RES_OFF, r);
    check("t5_result", r, model_dot(40'h500, 40'h600, 24));
    csr_rd(A_OFF, r);
    check("t5_a_base_kept", r, 64'h500);
    check("t5_addrs_done", exp_addr.size(), 0);

    // 6: reset while waiting on the B beat, then deliver the stale beat
    hold_idx = beat_cnt + 1;
    csr_wr(A_OFF, 64'h100, 0);
    csr_wr(B_OFF, 64'h200, 0);
    csr_wr(LEN_OFF, 64'd4, 0);
    push_addrs(40'h100, 40'h200, 4);
    csr_wr(START_OFF, 64'd1, 0);
    n = 0;
    while (beat_cnt <= hold_idx && n < 100) begin @(posedge clk); n++; end
    check("t6_reached_resp_b", beat_cnt, hold_idx + 1);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    exp_addr.delete();
    hold_idx = -1;
    check("t6_rst_cmd_ready", csr_cmd_ready_o, 1);
    check("t6_rst_mem_cmd_v", mem_cmd_v_o, 0);
    check("t6_idle_resp_ready", mem_resp_ready_o, 1);
    repeat (3) @(posedge clk);
    check("t6_stale_beat_taken", pend_addr.size(), 0);
    for (int k = 0; k < 6; k++) begin
      csr_rd(8'(8 * k), s);
      check("t6_csr_cleared", s, 64'd0);
    end
    run_op("t6", 40'h100, 40'h200, 4, r);
    check("t6_result", r, 64'd70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
